// File: rtl/calc_seq_ctrl.sv
// Multi-cycle sequencer for the calculator datapath: add/sub in one execute cycle, shift-add multiply, restoring divide.
// Latency: 2 edges (add/sub/div-by-zero) or WIDTH+2 edges (mul/div) after acceptance; start is ignored whenever ready=0.
module calc_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           operator,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     remainder,
  output logic                 sign,
  output logic                 err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    ITER   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         op_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] shreg;
  logic [WIDTH-1:0]   rem_r;
  logic [CW-1:0]      count;
  logic               sign_r;
  logic               err_r;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   abs_diff;
  logic [WIDTH:0]     rem_t;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;

  assign sum      = {1'b0, a_r} + {1'b0, b_r};
  assign abs_diff = (a_r >= b_r) ? (a_r - b_r) : (b_r - a_r);

  // shreg starts as a and shifts left once per step, so bit WIDTH-1 walks the dividend MSB first
  assign rem_t    = {rem_r, shreg[WIDTH-1]};
  assign div_ge   = (rem_t >= {1'b0, b_r});
  assign rem_next = div_ge ? WIDTH'(rem_t - {1'b0, b_r}) : rem_t[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (op_r == OP_MUL || (op_r == OP_DIV && b_r != '0)) begin
          next_state = ITER;
        end else begin
          next_state = FINISH;
        end
      end
      ITER: begin
        if (count == LAST_STEP) begin
          next_state = FINISH;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      acc       <= '0;
      shreg     <= '0;
      rem_r     <= '0;
      count     <= '0;
      sign_r    <= 1'b0;
      err_r     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      sign      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= operator;
          end
        end
        EXEC: begin
          // every op starts from clean internals so stale sign/err never leak
          acc    <= '0;
          rem_r  <= '0;
          count  <= '0;
          sign_r <= 1'b0;
          err_r  <= 1'b0;
          shreg  <= (2*WIDTH)'(a_r);
          case (op_r)
            OP_ADD: acc <= (2*WIDTH)'(sum);
            OP_SUB: begin
              acc    <= (2*WIDTH)'(abs_diff);
              sign_r <= (a_r < b_r);
            end
            OP_DIV: err_r <= (b_r == '0);
            default: ;
          endcase
        end
        ITER: begin
          count <= count + CW'(1);
          shreg <= shreg << 1;
          if (op_r == OP_MUL) begin
            if (b_r[count]) begin
              acc <= acc + shreg;
            end
          end else begin
            acc   <= {acc[2*WIDTH-2:0], div_ge};
            rem_r <= rem_next;
          end
        end
        FINISH: begin
          result    <= acc;
          remainder <= rem_r;
          sign      <= sign_r;
          err       <= err_r;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Multi-cycle sequencer for the 4-bit calculator datapath; replaces the purely combinational add/sub/mul/div paths.
- Takes one operation request through a start/ready handshake.
- Runs add/sub in one execute cycle, multiply as an iterative shift-add and divide as an iterative restoring divide.
- Presents a registered result, sign, remainder and error flag to the display/digit-extraction logic, with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand width; result width is 2*WIDTH; iteration count for mul/div is WIDTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on an edge where start=1 and ready=1.
- a  in  WIDTH  operand 1 (unsigned).
- b  in  WIDTH  operand 2 (unsigned).
- operator  in  2  00=div, 01=add, 10=sub, 11=mul.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; result fields updated on the same edge.
- result  out  2*WIDTH  sum, |a-b|, product or quotient (zero-extended).
- remainder  out  WIDTH  division remainder; 0 for other ops.
- sign  out  1  1 only for sub with a<b.
- err  out  1  1 only for div with b=0.

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state=IDLE, ready=1, done=0, result=0, remainder=0, sign=0, err=0.
  - Iteration counter and accumulators cleared.
  - rst has priority over start.
- States: IDLE, EXEC, ITER, FINISH.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch a, b, operator into internal regs; go to EXEC; ready drops the next cycle.
  - a, b, operator are sampled only at acceptance; later input changes have no effect.
- EXEC (1 cycle):
  - add: acc = a+b (WIDTH+1 bits, zero-extended).
  - sub: if a>=b then acc=a-b, sign_n=0; else acc=b-a, sign_n=1.
  - div with b=0: err_n=1, acc=0, rem=0.
  - add, sub and div-by-zero go to FINISH.
  - mul/div otherwise: init acc=0, rem=0, count=0; go to ITER.
- ITER, mul (one step per cycle, WIDTH cycles):
  - Step i (LSB first): if b_latched[i], acc += a_latched << i.
- ITER, div (restoring, MSB first, WIDTH cycles):
  - Step: rem_t = {rem, a_latched[WIDTH-1-i]}.
  - If rem_t >= b: rem = rem_t - b, quotient bit = 1; else rem = rem_t, bit = 0.
- ITER exit: count reaching WIDTH-1 moves to FINISH after that step.
- FINISH (1 cycle):
  - Update result, remainder, sign and err from internals.
  - Pulse done=1 for this cycle only; return to IDLE.
  - ready=0 during FINISH, so a start in the FINISH cycle is ignored.
- Latency, counted in edges after the acceptance edge:
  - add/sub/div-by-zero: outputs and done visible after edge 2.
  - mul/div: outputs and done visible after edge WIDTH+2 (6 at default).
  - Next request accepted at earliest on the edge after done.
- Output holding: result, remainder, sign and err hold their values until the next FINISH or reset.
  - Each FINISH rewrites all four; a new op clears the stale sign/err.
- Start while busy (ready=0): ignored with no side effects.
- Widths:
  - Product max (2^WIDTH-1)^2 fits 2*WIDTH.
  - Sum max fits WIDTH+1.
  - No overflow flag.

Test Plan:
- Add: reset, then start with a=9, b=7, op=01 → done after edge 2; result=16, sign=0, err=0, remainder=0.
- Sub: a=3, b=8, op=10 → after edge 2 result=5, sign=1. Follow with a=8, b=3 → result=5, sign=0 (sign cleared).
- Mul: a=15, b=15, op=11 → ready=0 for 6 cycles; done after edge 6; result=225. Also check a=0, b=13 → result=0.
- Div:
  - a=13, b=4, op=00 → after edge 6 result=3, remainder=1.
  - a=4, b=0 → after edge 2 err=1, result=0, remainder=0.
  - A subsequent a=4, b=2 div → err=0, result=2.
- Busy and mid-op reset:
  - Start a mul 15×15; toggle start with different operands during ITER → ignored, result still 225.
  - Start 15×15 again, assert rst at edge 3 → next cycle ready=1, result=0, no done pulse.
  - Then start 2+2 → result=4.
- Back-to-back:
  - Hold start=1 continuously with a=1, b=1, op=01 → one operation per 3 edges.
  - done never asserted on consecutive cycles; no request accepted during the FINISH cycle.
